// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus falling-edge detect.
// All flops reset to 1 (idle line level).
module uart_rx_sync (
  input  logic clk,
  input  logic areset,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  logic rx_m_q;
  logic rx_s_q;
  logic rx_prev_q;

  always_ff @(posedge clk) begin
    if (areset) begin
      rx_m_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_m_q    <= rx;
      rx_s_q    <= rx_m_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign rx_s    = rx_s_q;
  assign rx_fall = rx_prev_q & ~rx_s_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start/data/parity/stop framing driven by the
// oversample tick, with divider re-phasing on each start edge.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = PAR_NONE
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 tick_en,
  input  logic                 rx,
  output logic                 div_sync,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          ODD_SEL  = (PARITY == PAR_ODD);
  localparam logic          HAS_PAR  = (PARITY != PAR_NONE);

  logic rx_s;
  logic rx_fall;

  uart_rx_sync u_sync (
    .clk     (clk),
    .areset  (areset),
    .rx      (rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 par_bad_q;
  logic                 data_valid_q;
  logic                 frame_err_q;
  logic                 parity_err_q;

  // Asserted in the same cycle the edge is seen, so any tick_en in that
  // cycle lands while still in IDLE and is not counted.
  assign div_sync   = (state_q == IDLE) && rx_fall;
  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign busy       = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      par_bad_q    <= 1'b0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_fall) begin
            cnt_q     <= '0;
            par_bad_q <= 1'b0;
            state_q   <= START;
          end
        end
        START: begin
          if (tick_en) begin
            if (cnt_q == CNT_MID) begin
              cnt_q   <= '0;
              bit_q   <= '0;
              state_q <= rx_s ? IDLE : DATA;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        DATA: begin
          if (tick_en) begin
            if (cnt_q == CNT_END) begin
              cnt_q   <= '0;
              shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
              if (bit_q == BIT_LAST) begin
                bit_q   <= '0;
                state_q <= HAS_PAR ? PAR : STOP;
              end else begin
                bit_q <= bit_q + BW'(1);
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        PAR: begin
          if (tick_en) begin
            if (cnt_q == CNT_END) begin
              cnt_q     <= '0;
              par_bad_q <= ((^shift_q) ^ rx_s) != ODD_SEL;
              state_q   <= STOP;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        STOP: begin
          if (tick_en) begin
            if (cnt_q == CNT_END) begin
              cnt_q   <= '0;
              state_q <= IDLE;
              if (rx_s && !par_bad_q) begin
                data_q       <= shift_q;
                data_valid_q <= 1'b1;
              end else begin
                frame_err_q  <= ~rx_s;
                parity_err_q <= par_bad_q;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
